mem_line_responder: RTL and testbench
=====================================

# mem_line_responder

Memory-side responder for the instruction/data cache line-fill interface. It accepts single-line read or write requests from a cache (`mem_read`/`mem_write`, 28-bit line address), services them from an internal 128-bit-wide line store after a fixed, parameterised latency, and signals completion with a one-cycle `mem_ready` pulse. It sits between the cache's memory port and the system, and replaces the behavioural memory model in synthesizable builds and benches. A side-band load port lets a boot loader or testbench preload lines.

## Interface
- `DEPTH_LOG2`, default 8 — line-index bits; the store holds 2^DEPTH_LOG2 lines of 128 bits.
- `LATENCY`, default 4 — cycles from request acceptance to `mem_ready`; legal range 1..15.
- `clk` in 1 — single clock; all state is updated on the rising edge.
- `proc_reset_n` in 1 — asynchronous, active-low reset.
- `mem_read` in 1 — line read request; held high by the cache until it sees `mem_ready`.
- `mem_write` in 1 — line write request; held high until `mem_ready`.
- `mem_addr` in 28 — line address; only bits [DEPTH_LOG2-1:0] are used.
- `mem_wdata` in 128 — write line; sampled at acceptance.
- `mem_ready` out 1 — one-cycle completion pulse; registered.
- `mem_rdata` out 128 — read line; registered and valid in the `mem_ready` cycle. Holds its value until the next read completes.
- `ld_en` in 1 — preload strobe.
- `ld_addr` in DEPTH_LOG2 — preload line index.
- `ld_data` in 128 — preload line.
- `busy` out 1 — high whenever the state is not IDLE.
- `req_count` out 16 — number of completed transactions; wraps modulo 2^16.
- `err_both` out 1 — sticky flag; set when `mem_read` and `mem_write` are seen high together in IDLE.

## Operation
- States: IDLE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - If `mem_read` or `mem_write` is high, the request is accepted at the edge: `mem_addr` index, op and `mem_wdata` are latched, and the latency counter is loaded with LATENCY-1.
  - Next state is RESP when LATENCY=1, otherwise WAIT.
  - If both requests are high, the read wins, the write is dropped, and `err_both` is set to 1.
- **WAIT**
  - The counter decrements each cycle; the block moves to RESP at the edge where the counter reaches 1.
  - Request inputs are ignored; the cache is required to hold them stable.
- **Entering RESP**
  - Read: `mem_rdata` is loaded from the array at the latched index (the array is read at this edge, not at acceptance).
  - Write: the latched wdata is committed to the array at this edge.
- **RESP**
  - `mem_ready` is 1 for exactly one cycle.
  - `req_count` increments at the exit edge.
  - Next state is always IDLE; no back-to-back acceptance from RESP.
- **Address**
  - Index is `mem_addr[DEPTH_LOG2-1:0]`; upper bits alias (wrap-around).
- **Load port**
  - `ld_en` writes `ld_data` to `ld_addr` at the edge, in any state.
  - If the load targets the same index as a write committing at the same edge, the load wins.
  - A load before or at the RESP-entry edge of a read to the same index is visible in `mem_rdata`.
- **Reset**
  - Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=0, `busy`=0, `req_count`=0, `err_both`=0, counter 0.
  - Array contents are not reset.
  - Reset asserted mid-transaction aborts it: no `mem_ready` pulse, and no array write occurs.

## Timing
- Request high during IDLE cycle c → `mem_ready` high during cycle c+LATENCY, and low in all other cycles.
- Minimum request-to-request spacing is LATENCY+1 cycles.
  - The cache drops its request in the cycle after `mem_ready`, which the responder sees in IDLE.
  - A request still high in that cycle is treated as a new request.
- `busy` rises in cycle c+1 and falls in cycle c+LATENCY+1.
- `mem_rdata` changes only at a read's RESP-entry edge.
- The array is written only at a write's RESP-entry edge or at a load.

## Test plan
- Reset, then check outputs → `mem_ready`=0, `mem_rdata`=0, `busy`=0, `req_count`=0, `err_both`=0.
- Preload index 5 = 0x0123…CDEF (128-bit). Assert `mem_read` with `mem_addr`=0x0000005 at cycle 10, LATENCY=4 → `mem_ready` is high only in cycle 14, `mem_rdata`=0x0123…CDEF, `req_count`=1.
- Write `mem_addr`=0x0000105 (aliases to index 5 when DEPTH_LOG2=8) with data 0xAAAA…, then read index 5 → read returns 0xAAAA…, with two `mem_ready` pulses 5 cycles apart.
- LATENCY=1: read accepted at cycle c → `mem_ready` in c+1, and `busy` high only during c+1.
- `mem_read`=`mem_write`=1 together → the read is serviced, the array is unchanged, and `err_both`=1 and stays 1.
- Assert `proc_reset_n`=0 during WAIT of a write to index 7 → no `mem_ready` pulse, and index 7 keeps its old contents. Separately, `ld_en` to index 3 on the same edge as a write-commit to index 3 → index 3 holds `ld_data`.

Source files
------------

// File: rtl/mem_line_responder.sv
// Memory-side line responder: services single-line read/write requests from a
// cache after a fixed latency, with a side-band preload port into the line store.
module mem_line_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  proc_reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [27:0]           mem_addr,
  input  logic [127:0]          mem_wdata,
  output logic                  mem_ready,
  output logic [127:0]          mem_rdata,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [127:0]          ld_data,
  output logic                  busy,
  output logic [15:0]           req_count,
  output logic                  err_both
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LINE_W = 128;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_is_write;
  logic [LINE_W-1:0]     r_wdata;
  logic [LINE_W-1:0]     r_mem [DEPTH];

  logic                  w_req;
  logic                  w_idle;
  logic                  w_enter_resp;
  logic [DEPTH_LOG2-1:0] w_enter_idx;
  logic                  w_enter_write;
  logic [LINE_W-1:0]     w_enter_wdata;
  logic                  w_ld_hit;
  logic                  w_commit;
  logic [LINE_W-1:0]     w_rd_line;
  logic                  w_unused_addr;

  assign w_req  = mem_read | mem_write;
  assign w_idle = (r_state == S_IDLE);

  // With LATENCY=1 the acceptance edge is also the RESP-entry edge, so the
  // transaction fields come straight from the inputs instead of the latches.
  assign w_enter_resp  = proc_reset_n &&
                         ((w_idle && w_req && (LATENCY == 1)) ||
                          ((r_state == S_WAIT) && (r_cnt == CNT_W'(1))));
  assign w_enter_idx   = w_idle ? mem_addr[DEPTH_LOG2-1:0] : r_idx;
  assign w_enter_write = w_idle ? !mem_read : r_is_write;
  assign w_enter_wdata = w_idle ? mem_wdata : r_wdata;

  // A same-edge preload to the target index overrides the commit and is forwarded to reads.
  assign w_ld_hit  = ld_en && (ld_addr == w_enter_idx);
  assign w_commit  = w_enter_resp && w_enter_write && !w_ld_hit;
  assign w_rd_line = w_ld_hit ? ld_data : r_mem[w_enter_idx];

  assign w_unused_addr = ^mem_addr[27:DEPTH_LOG2];

  // Line store: not reset; written only by a write commit or a preload.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_enter_idx] <= w_enter_wdata;
    end
    if (ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_is_write <= 1'b0;
      r_wdata    <= '0;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      busy       <= 1'b0;
      req_count  <= '0;
      err_both   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx      <= mem_addr[DEPTH_LOG2-1:0];
            r_is_write <= !mem_read;
            r_wdata    <= mem_wdata;
            r_cnt      <= CNT_W'(LATENCY - 1);
            busy       <= 1'b1;
            r_state    <= (LATENCY == 1) ? S_RESP : S_WAIT;
            if (mem_read && mem_write) begin
              err_both <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          busy      <= 1'b0;
          req_count <= req_count + 16'd1;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
      if (w_enter_resp) begin
        mem_ready <= 1'b1;
        if (!w_enter_write) begin
          mem_rdata <= w_rd_line;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: a LATENCY=4 instance for the main
// scenarios and a LATENCY=1 instance for the minimum-latency case.
module tb_mem_line_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic         ld_en;
  logic [7:0]   ld_addr;
  logic [127:0] ld_data;
  logic         busy;
  logic [15:0]  req_count;
  logic         err_both;

  logic         m1_read, m1_write;
  logic [27:0]  m1_addr;
  logic [127:0] m1_wdata;
  logic         m1_ready;
  logic [127:0] m1_rdata;
  logic         ld1_en;
  logic [7:0]   ld1_addr;
  logic [127:0] ld1_data;
  logic         m1_busy;
  logic [15:0]  m1_count;
  logic         m1_err;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] PAT5 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] PATA = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
  localparam logic [127:0] PAT9 = 128'h99990000999900009999000099990000;
  localparam logic [127:0] PATY = 128'h5555666677778888555566667777FFFF;
  localparam logic [127:0] OLD7 = 128'h0000000000000000000000000000_7007;
  localparam logic [127:0] NEW7 = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam logic [127:0] WR3  = 128'h33333333333333333333333333333333;
  localparam logic [127:0] LD3  = 128'hC0FFEE00C0FFEE00C0FFEE00C0FFEE00;
  localparam logic [127:0] PAT2 = 128'h22220000000000000000000000002222;

  mem_line_responder #(.DEPTH_LOG2(8), .LATENCY(4)) dut (
    .clk(clk), .proc_reset_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .req_count(req_count), .err_both(err_both)
  );

  mem_line_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .proc_reset_n(rst_n),
    .mem_read(m1_read), .mem_write(m1_write), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_ready(m1_ready), .mem_rdata(m1_rdata),
    .ld_en(ld1_en), .ld_addr(ld1_addr), .ld_data(ld1_data),
    .busy(m1_busy), .req_count(m1_count), .err_both(m1_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [127:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Issues a read on the LATENCY=4 instance; reports the cycle offset of the
  // first ready pulse (-1 if none within the budget) and the line it returned.
  task automatic run_read(input logic [27:0] a, output int rk, output logic [127:0] d);
    rk = -1; d = '0;
    mem_read = 1'b1; mem_addr = a;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (mem_ready && rk < 0) begin
        rk = k; d = mem_rdata; mem_read = 1'b0;
      end
    end
    mem_read = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    ld_en = 0; ld_addr = '0; ld_data = '0;
    m1_read = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
    ld1_en = 0; ld1_addr = '0; ld1_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", mem_ready); end
    total++; if (mem_rdata !== 128'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (req_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", req_count); end
    total++; if (err_both !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_both); end
  endtask

  task automatic test_read();
    logic exp_busy;
    preload(8'd5, PAT5);
    mem_read = 1'b1; mem_addr = 28'h0000005;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_busy = (k <= 4);
      total++; if (mem_ready !== (k == 4)) begin bad++; $display("FAIL read_ready k=%0d got=%b exp=%b", k, mem_ready, (k == 4)); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL read_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
      if (k == 4) begin
        total++; if (mem_rdata !== PAT5) begin bad++; $display("FAIL read_data got=%h exp=%h", mem_rdata, PAT5); end
        mem_read = 1'b0;
      end
    end
    total++; if (req_count !== 16'd1) begin bad++; $display("FAIL read_count got=%0d exp=1", req_count); end
  endtask

  task automatic test_back_to_back();
    mem_write = 1'b1; mem_addr = 28'h0000105; mem_wdata = PATA;
    for (int k = 1; k <= 11; k++) begin
      tick();
      total++; if (mem_ready !== (k == 4 || k == 9)) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, mem_ready, (k == 4 || k == 9)); end
      if (k == 4) begin
        total++; if (mem_rdata !== PAT5) begin bad++; $display("FAIL b2b_rdata_hold got=%h exp=%h", mem_rdata, PAT5); end
        mem_write = 1'b0; mem_read = 1'b1; mem_addr = 28'h0000005;
      end
      if (k == 9) begin
        total++; if (mem_rdata !== PATA) begin bad++; $display("FAIL b2b_alias_data got=%h exp=%h", mem_rdata, PATA); end
        mem_read = 1'b0;
      end
    end
    total++; if (req_count !== 16'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", req_count); end
  endtask

  task automatic test_both();
    int rk;
    logic [127:0] d;
    preload(8'd9, PAT9);
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 28'h0000009; mem_wdata = PATY;
    tick();
    total++; if (err_both !== 1'b1) begin bad++; $display("FAIL both_err_set got=%b exp=1", err_both); end
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (k == 4) begin
        total++; if (mem_ready !== 1'b1 || mem_rdata !== PAT9) begin bad++; $display("FAIL both_read got=%b/%h exp=1/%h", mem_ready, mem_rdata, PAT9); end
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    run_read(28'h0000009, rk, d);
    total++; if (rk !== 4) begin bad++; $display("FAIL both_reread_lat got=%0d exp=4", rk); end
    total++; if (d !== PAT9) begin bad++; $display("FAIL both_array_kept got=%h exp=%h", d, PAT9); end
    total++; if (err_both !== 1'b1) begin bad++; $display("FAIL both_err_sticky got=%b exp=1", err_both); end
    total++; if (req_count !== 16'd5) begin bad++; $display("FAIL both_count got=%0d exp=5", req_count); end
  endtask

  task automatic test_latency1();
    ld1_en = 1'b1; ld1_addr = 8'd2; ld1_data = PAT2;
    tick();
    ld1_en = 1'b0;
    m1_read = 1'b1; m1_addr = 28'h0000002;
    total++; if (m1_busy !== 1'b0) begin bad++; $display("FAIL lat1_busy_pre got=%b exp=0", m1_busy); end
    tick();
    total++; if (m1_ready !== 1'b1 || m1_busy !== 1'b1) begin bad++; $display("FAIL lat1_resp got=%b/%b exp=1/1", m1_ready, m1_busy); end
    total++; if (m1_rdata !== PAT2) begin bad++; $display("FAIL lat1_data got=%h exp=%h", m1_rdata, PAT2); end
    m1_read = 1'b0;
    tick();
    total++; if (m1_ready !== 1'b0 || m1_busy !== 1'b0) begin bad++; $display("FAIL lat1_after got=%b/%b exp=0/0", m1_ready, m1_busy); end
    total++; if (m1_count !== 16'd1) begin bad++; $display("FAIL lat1_count got=%0d exp=1", m1_count); end
  endtask

  task automatic test_reset_abort();
    int rk;
    logic [127:0] d;
    preload(8'd7, OLD7);
    mem_write = 1'b1; mem_addr = 28'h0000007; mem_wdata = NEW7;
    tick(); tick();
    rst_n = 1'b0; mem_write = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || err_both !== 1'b0) begin bad++; $display("FAIL abort_reset got=%b/%b exp=0/0", busy, err_both); end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL abort_no_ready k=%0d got=%b exp=0", k, mem_ready); end
    end
    run_read(28'h0000007, rk, d);
    total++; if (rk !== 4 || d !== OLD7) begin bad++; $display("FAIL abort_array got=%0d/%h exp=4/%h", rk, d, OLD7); end
  endtask

  task automatic test_load_collision();
    int rk;
    logic [127:0] d;
    mem_write = 1'b1; mem_addr = 28'h0000003; mem_wdata = WR3;
    tick(); tick(); tick();
    ld_en = 1'b1; ld_addr = 8'd3; ld_data = LD3;
    tick();
    ld_en = 1'b0;
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL coll_ready got=%b exp=1", mem_ready); end
    mem_write = 1'b0;
    tick();
    run_read(28'h0000003, rk, d);
    total++; if (rk !== 4 || d !== LD3) begin bad++; $display("FAIL coll_load_wins got=%0d/%h exp=4/%h", rk, d, LD3); end
  endtask

  initial begin
    test_reset();
    repeat (3) tick();
    test_read();
    test_back_to_back();
    test_both();
    test_latency1();
    test_reset_abort();
    test_load_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
